// File: rtl/rr_sel_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_sel_mux_if
//  Description : Handshake/data bundle between N producers, the rr_sel_mux
//                arbiter and its single consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface rr_sel_mux_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
);
   localparam int SELW = $clog2(NCH);

   logic                   mode;
   logic [SELW-1:0]        sel;
   logic [NCH-1:0]         in_valid;
   logic [NCH*WIDTH-1:0]   in_data;
   logic [NCH-1:0]         in_ready;
   logic                   out_valid;
   logic [WIDTH-1:0]       out_data;
   logic [SELW-1:0]        out_chan;
   logic                   out_ready;

   // Producer/consumer side: drives requests and consumer ready
   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_chan
   );

   // Arbiter side
   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_chan
   );
endinterface
`default_nettype wire

// File: rtl/rr_sel_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rr_sel_mux
//  Description : N-channel select/arbitration multiplexer with valid/ready
//                on every input and a one-beat registered output. Fixed mode
//                picks the channel named by sel; round-robin mode rotates
//                among valid channels starting at a rotating pointer.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_sel_mux #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
) (
   input  wire logic    clk,
   input  wire logic    rst,
   rr_sel_mux_if.slave  bus
);
   localparam int SELW       = $clog2(NCH);
   localparam int C_SEL_SPAN = 2 ** SELW;

   // ---------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------
   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q,  out_data_d;
   logic [SELW-1:0]     out_chan_q,  out_chan_d;
   logic [SELW-1:0]     ptr_q,       ptr_d;

   // ---------------------------------------------------------------------
   // Combinational arbitration signals
   // ---------------------------------------------------------------------
   logic [C_SEL_SPAN-1:0] w_valid_pad;
   logic                  w_fix_vld;
   logic                  w_rr_vld;
   logic [SELW-1:0]       w_rr_idx;
   logic [SELW:0]         w_rr_pos;
   logic                  w_grant_vld;
   logic [SELW-1:0]       w_grant_idx;
   logic                  w_load_en;
   logic                  w_xfer;
   logic [NCH-1:0]        w_in_ready;
   logic [WIDTH-1:0]      w_grant_data;

   // Valid vector padded to the full select range so that an out-of-range
   // sel (possible when NCH is not a power of two) reads as "not valid".
   always_comb begin
      w_valid_pad          = '0;
      w_valid_pad[NCH-1:0] = bus.in_valid;
   end

   // Fixed mode: grant only if the selected channel exists and is valid.
   assign w_fix_vld = w_valid_pad[bus.sel];

   // Round-robin search: first valid channel at or after ptr, wrapping.
   always_comb begin
      w_rr_vld = 1'b0;
      w_rr_idx = '0;
      w_rr_pos = '0;
      for (int k = 0; k < NCH; k++) begin
         w_rr_pos = {1'b0, ptr_q} + (SELW+1)'(k);
         if (w_rr_pos >= (SELW+1)'(NCH)) begin
            w_rr_pos = w_rr_pos - (SELW+1)'(NCH);
         end
         if (!w_rr_vld && bus.in_valid[w_rr_pos[SELW-1:0]]) begin
            w_rr_vld = 1'b1;
            w_rr_idx = w_rr_pos[SELW-1:0];
         end
      end
   end

   // Mode chooses which arbiter result is live this cycle.
   always_comb begin
      if (bus.mode) begin
         w_grant_vld = w_rr_vld;
         w_grant_idx = w_rr_idx;
      end else begin
         w_grant_vld = w_fix_vld;
         w_grant_idx = bus.sel;
      end
   end

   // The output register can take a beat when empty or being drained now.
   assign w_load_en = !out_valid_q || bus.out_ready;
   assign w_xfer    = !rst && w_load_en && w_grant_vld;

   // One-hot ready toward the granted producer only.
   always_comb begin
      w_in_ready = '0;
      for (int i = 0; i < NCH; i++) begin
         w_in_ready[i] = w_xfer && (w_grant_idx == SELW'(i));
      end
   end

   // Data of the granted channel.
   always_comb begin
      w_grant_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant_idx == SELW'(i)) begin
            w_grant_data = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next state of the output register and round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      ptr_d       = ptr_q;
      if (w_load_en) begin
         out_valid_d = w_grant_vld;
         if (w_grant_vld) begin
            out_data_d = w_grant_data;
            out_chan_d = w_grant_idx;
            if (bus.mode) begin
               ptr_d = (w_grant_idx == SELW'(NCH-1)) ? '0
                                                     : w_grant_idx + SELW'(1);
            end
         end
      end
   end

   // State register with synchronous reset; a held beat is discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;

   // At most one producer is accepted, and only a producer that is valid.
   a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(bus.in_ready));
   a_ready_implies_valid: assert property (@(posedge clk) disable iff (rst)
      (bus.in_ready & ~bus.in_valid) == '0);

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_sel_mux
//  Description : Scoreboard bench for rr_sel_mux in three builds
//                (NCH=4/W=8, NCH=3/W=8, NCH=16/W=32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_sel_mux;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;

   rr_sel_mux_if #(.WIDTH(8),  .NCH(4))  a_if();
   rr_sel_mux_if #(.WIDTH(8),  .NCH(3))  b_if();
   rr_sel_mux_if #(.WIDTH(32), .NCH(16)) c_if();

   rr_sel_mux #(.WIDTH(8),  .NCH(4))  u_a (.clk(clk), .rst(rst_a), .bus(a_if.slave));
   rr_sel_mux #(.WIDTH(8),  .NCH(3))  u_b (.clk(clk), .rst(rst_b), .bus(b_if.slave));
   rr_sel_mux #(.WIDTH(32), .NCH(16)) u_c (.clk(clk), .rst(rst_c), .bus(c_if.slave));

   int total = 0;
   int bad   = 0;

   // Expected beats: {chan[3:0], data[31:0]}
   logic [35:0] q_a[$];
   logic [35:0] q_b[$];
   logic [35:0] q_c[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic no_beat_fail(input string name, input logic [35:0] act);
      total++;
      bad++;
      $display("FAIL %s: got beat %0h required none", name, act);
   endtask

   // Monitors: pop and compare whenever a held beat is consumed.
   always @(negedge clk) begin
      if (!rst_a && a_if.out_valid && a_if.out_ready) begin
         if (q_a.size() == 0) no_beat_fail("a_beat", {4'(a_if.out_chan), 32'(a_if.out_data)});
         else check("a_beat", 64'({4'(a_if.out_chan), 32'(a_if.out_data)}), 64'(q_a.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (!rst_b && b_if.out_valid && b_if.out_ready) begin
         if (q_b.size() == 0) no_beat_fail("b_beat", {4'(b_if.out_chan), 32'(b_if.out_data)});
         else check("b_beat", 64'({4'(b_if.out_chan), 32'(b_if.out_data)}), 64'(q_b.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (!rst_c && c_if.out_valid && c_if.out_ready) begin
         if (q_c.size() == 0) no_beat_fail("c_beat", {4'(c_if.out_chan), c_if.out_data});
         else check("c_beat", 64'({4'(c_if.out_chan), c_if.out_data}), 64'(q_c.pop_front()));
      end
   end

   task automatic step_a(input logic r, input logic m, input logic [1:0] s,
                         input logic [3:0] v, input logic ordy,
                         input logic [3:0] exp_rdy, input logic push,
                         input logic [7:0] ed, input logic [1:0] ec);
      rst_a = r; a_if.mode = m; a_if.sel = s; a_if.in_valid = v; a_if.out_ready = ordy;
      @(negedge clk);
      check("a_in_ready", 64'(a_if.in_ready), 64'(exp_rdy));
      if (push) q_a.push_back({4'(ec), 32'(ed)});
      @(posedge clk); #1;
   endtask

   task automatic step_b(input logic r, input logic [1:0] s, input logic [2:0] v,
                         input logic [2:0] exp_rdy, input logic push,
                         input logic [7:0] ed, input logic [1:0] ec);
      rst_b = r; b_if.mode = 1'b0; b_if.sel = s; b_if.in_valid = v; b_if.out_ready = 1'b1;
      @(negedge clk);
      check("b_in_ready", 64'(b_if.in_ready), 64'(exp_rdy));
      if (push) q_b.push_back({4'(ec), 32'(ed)});
      @(posedge clk); #1;
   endtask

   task automatic step_c(input logic r, input logic [15:0] v,
                         input logic [15:0] exp_rdy, input logic push,
                         input logic [31:0] ed, input logic [3:0] ec);
      rst_c = r; c_if.mode = 1'b1; c_if.sel = '0; c_if.in_valid = v; c_if.out_ready = 1'b1;
      @(negedge clk);
      check("c_in_ready", 64'(c_if.in_ready), 64'(exp_rdy));
      if (push) q_c.push_back({ec, ed});
      @(posedge clk); #1;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      a_if.mode = 1'b0; a_if.sel = '0; a_if.in_valid = '0; a_if.out_ready = 1'b0;
      b_if.mode = 1'b0; b_if.sel = '0; b_if.in_valid = '0; b_if.out_ready = 1'b0;
      c_if.mode = 1'b0; c_if.sel = '0; c_if.in_valid = '0; c_if.out_ready = 1'b0;
      a_if.in_data = 32'h4433_2211;
      b_if.in_data = 24'hA2_A1_A0;
      for (int i = 0; i < 16; i++) c_if.in_data[i*32 +: 32] = 32'hC000_0000 | 32'(i);
      @(posedge clk); #1;

      // ---- build A: NCH=4, WIDTH=8 ----
      step_a(1, 1, 0, 4'hF, 1, 4'b0000, 0, 8'h00, 0);
      step_a(1, 1, 0, 4'hF, 1, 4'b0000, 0, 8'h00, 0);
      check("a_rst_out_valid", 64'(a_if.out_valid), 64'd0);
      check("a_rst_out_data",  64'(a_if.out_data),  64'd0);
      check("a_rst_out_chan",  64'(a_if.out_chan),  64'd0);

      // round-robin, all valid: 0,1,2,3,0,1,2,3
      for (int k = 0; k < 8; k++)
         step_a(0, 1, 0, 4'hF, 1, 4'(1 << (k % 4)), 1, 8'(8'h11 * (k % 4 + 1)), 2'(k % 4));

      // fixed mode
      step_a(0, 0, 2, 4'hF, 1, 4'b0100, 1, 8'h33, 2);
      step_a(0, 0, 3, 4'hF, 1, 4'b1000, 1, 8'h44, 3);

      // ptr still 0: one grant to move ptr to 1, then sparse 1001
      step_a(0, 1, 0, 4'hF,    1, 4'b0001, 1, 8'h11, 0);
      step_a(0, 1, 0, 4'b1001, 1, 4'b1000, 1, 8'h44, 3);
      step_a(0, 1, 0, 4'b1001, 1, 4'b0001, 1, 8'h11, 0);
      step_a(0, 1, 0, 4'b1001, 1, 4'b1000, 1, 8'h44, 3);

      // no valid channel: output empties
      step_a(0, 1, 0, 4'b0000, 1, 4'b0000, 0, 8'h00, 0);
      check("a_empty_out_valid", 64'(a_if.out_valid), 64'd0);

      // load 22 then hold it under backpressure
      step_a(0, 0, 1, 4'hF, 1, 4'b0010, 1, 8'h22, 1);
      for (int k = 0; k < 3; k++) begin
         step_a(0, 1, 0, 4'hF, 0, 4'b0000, 0, 8'h00, 0);
         check("a_bp_out_valid", 64'(a_if.out_valid), 64'd1);
         check("a_bp_out_data",  64'(a_if.out_data),  64'h22);
         check("a_bp_out_chan",  64'(a_if.out_chan),  64'd1);
      end
      // drain and refill in one edge; ptr was unchanged at 0
      step_a(0, 1, 0, 4'hF, 1, 4'b0001, 1, 8'h11, 0);
      check("a_refill_out_valid", 64'(a_if.out_valid), 64'd1);
      step_a(0, 1, 0, 4'hF, 1, 4'b0010, 1, 8'h22, 1);

      // reset mid-operation with consumer ready: held beat is lost
      step_a(1, 1, 0, 4'hF, 1, 4'b0000, 0, 8'h00, 0);
      q_a.delete();
      check("a_midrst_out_valid", 64'(a_if.out_valid), 64'd0);
      step_a(0, 1, 0, 4'hF, 1, 4'b0001, 1, 8'h11, 0);
      step_a(0, 1, 0, 4'h0, 1, 4'b0000, 0, 8'h00, 0);
      check("a_queue_empty", 64'(q_a.size()), 64'd0);

      // ---- build B: NCH=3, sel beyond range ----
      step_b(1, 0, 3'b111, 3'b000, 0, 8'h00, 0);
      step_b(0, 0, 3'b111, 3'b001, 1, 8'hA0, 0);
      step_b(0, 3, 3'b111, 3'b000, 0, 8'h00, 0);
      check("b_sel3_out_valid", 64'(b_if.out_valid), 64'd0);
      step_b(0, 2, 3'b111, 3'b100, 1, 8'hA2, 2);
      step_b(0, 3, 3'b111, 3'b000, 0, 8'h00, 0);
      check("b_sel3b_out_valid", 64'(b_if.out_valid), 64'd0);
      check("b_queue_empty", 64'(q_b.size()), 64'd0);

      // ---- build C: NCH=16, WIDTH=32, pointer wrap ----
      step_c(1, 16'hFFFF, 16'h0000, 0, 32'h0, 0);
      step_c(0, 16'h4000, 16'h4000, 1, 32'hC000_000E, 14);
      step_c(0, 16'h8000, 16'h8000, 1, 32'hC000_000F, 15);
      step_c(0, 16'h8001, 16'h0001, 1, 32'hC000_0000, 0);
      step_c(0, 16'h8001, 16'h8000, 1, 32'hC000_000F, 15);
      step_c(0, 16'h0000, 16'h0000, 0, 32'h0, 0);
      check("c_queue_empty", 64'(q_c.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/rr_sel_mux.md
# rr_sel_mux

Parametrised, registered N-channel select/arbitration multiplexer with valid/ready handshaking on every input channel and on the output. Successor to the fixed 4:1 combinational byte mux: any width and channel count, a fixed-select mode compatible with the old behaviour, a round-robin arbitration mode, and a one-beat output register with backpressure. Sits between multiple producers (register file ports, immediate/ALU/memory result paths) and a single consumer in the CPU datapath.

## Interface
- WIDTH, 8, data width per channel
- NCH, 4, number of input channels, legal range 2..16
- SELW, $clog2(NCH) (derived, not overridden), width of select and channel-index fields
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- mode  input  1  0 = fixed select by sel, 1 = round-robin among valid channels
- sel  input  SELW  channel index used in fixed mode; ignored in round-robin mode
- in_valid  input  NCH  per-channel data valid
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  NCH  per-channel accept; at most one bit set per cycle
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered data of held beat
- out_chan  output  SELW  index of channel that supplied held beat
- out_ready  input  1  consumer accepts the held beat this cycle

## Operation
- Output register empty or draining: load_en = !out_valid || out_ready.
- Grant g computed combinationally every cycle from mode, sel, in_valid, pointer ptr.
- Fixed mode: grant exists iff sel < NCH and in_valid[sel]; g = sel. sel >= NCH -> no grant, all in_ready low.
- Round-robin mode: search channels ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (wrap); g = first with in_valid set. No valid channel -> no grant.
- in_ready[g] = load_en && grant exists; all other in_ready bits 0. in_ready[i] is never high when in_valid[i] is low.
- Transfer on channel g when in_valid[g] && in_ready[g]: at next edge out_valid<=1, out_data<=in_data[g], out_chan<=g.
- load_en && no grant: out_valid<=0; out_data/out_chan hold previous values.
- !load_en (out_valid && !out_ready): out_valid, out_data, out_chan all hold; no input accepted.
- ptr: updates only on a round-robin-mode transfer, ptr<=(g+1) mod NCH (g=NCH-1 wraps to 0). Unchanged in fixed mode and on cycles with no transfer.
- mode/sel changes take effect in the same cycle (combinational); a held output beat is unaffected.
- Simultaneous drain and refill (out_valid && out_ready && grant): old beat consumed and new beat loaded in the same edge; out_valid stays 1.

## Timing
- Reset (rst high at edge): out_valid=0, out_data=0, out_chan=0, ptr=0. in_ready is all-0 while rst is high regardless of inputs; no transfer occurs in a reset cycle.
- Reset mid-operation drops any held beat (it is lost); the first cycle after rst deasserts behaves as empty register, RR search from channel 0.
- Latency: input transfer at edge N -> out_valid/out_data visible after edge N, consumable in cycle N+1.
- Throughput: one beat per cycle when out_ready held high.
- in_ready is combinational from in_valid, mode, sel, out_valid, out_ready, rst; out_* are registers only (no combinational input-to-output path).
- Fairness: in round-robin mode with all NCH channels continuously valid and out_ready high, each channel granted exactly once per NCH consecutive transfers.

## Test plan
- Reset: drive rst=1 with in_valid=4'b1111 for 2 cycles -> in_ready=0000, out_valid=0, out_data=0, out_chan=0; deassert, mode=1 -> first grant channel 0.
- Fixed mode, WIDTH=8, NCH=4: sel=2, in_data={D:8'h44,C:8'h33,B:8'h22,A:8'h11}, in_valid=1111, out_ready=1 -> in_ready=0100, next cycle out_data=8'h33, out_chan=2; sel=3 -> 8'h44, chan 3.
- Round-robin, all valid, out_ready=1, 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3, one beat per cycle.
- Round-robin sparse: in_valid=1001, ptr=1 -> grant 3, ptr->0; next grant 0, ptr->1; next grant 3.
- Backpressure: out_valid=1 holding 8'h22, out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000, out_data/out_chan stable, ptr unchanged; out_ready=1 -> drain and refill same edge, out_valid stays 1.
- Boundaries: NCH=3 build, fixed mode sel=3 -> no grant, out_valid drops after drain; NCH=16, WIDTH=32 round-robin from ptr=15 with only channel 15 valid -> grant 15, ptr wraps to 0.
